// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch queue between fetch and decode.
// Circular buffer of DEPTH {PC, instruction} pairs with a valid/ready
// handshake on the decode side and a single-cycle flush for taken branches.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to let an entry pass straight
// from fetch to decode when the queue is empty (zero-cycle latency).
module fetch_queue #(
  parameter int WORD_LEN = 32,
  parameter int DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WORD_LEN-1:0]      in_pc,
  input  logic [WORD_LEN-1:0]      in_inst,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [WORD_LEN-1:0]      out_pc,
  output logic [WORD_LEN-1:0]      out_inst,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WORD_LEN-1:0] pc_mem   [DEPTH];
  logic [WORD_LEN-1:0] inst_mem [DEPTH];

  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  logic stored_valid;
  logic bypass;
  logic bypass_take;
  logic push;
  logic pop;

  assign stored_valid = (count_reg != '0);

  // Ready depends only on the registered occupancy, so a full queue refuses
  // a push even if decode pops in the same cycle.
  assign in_ready = (count_reg != CW'(DEPTH));

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue with a live fetch: present the incoming pair directly.
  assign bypass = ~stored_valid & in_valid & ~flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry that decode accepts is never written into storage.
  assign bypass_take = bypass & out_ready;

  assign push = in_valid & in_ready & ~flush & ~bypass_take;
  assign pop  = stored_valid & out_ready & ~flush;

  assign out_valid = stored_valid | bypass;
  assign count     = count_reg;

  // Head selection; decode sees all-zero (NOP) when nothing is valid.
  always_comb begin
    out_pc   = '0;
    out_inst = '0;
    if (stored_valid) begin
      out_pc   = pc_mem[rd_ptr_reg];
      out_inst = inst_mem[rd_ptr_reg];
    end else if (bypass) begin
      out_pc   = in_pc;
      out_inst = in_inst;
    end
  end

  // Occupancy update; flush wins over any same-cycle push or pop.
  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // Pointer and occupancy registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (flush) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
    end
  end

  // Entry storage; contents need no reset since occupancy gates the outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]   <= in_pc;
      inst_mem[wr_ptr_reg] <= in_inst;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a scoreboard monitor for fetch_queue.
// Accepted pushes are queued as expected entries; the monitor pops and
// compares whenever decode takes the head entry.
module tb_fetch_queue;

  localparam int WORD_LEN = 32;
  localparam int DEPTH    = 4;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic [WORD_LEN-1:0] in_pc;
  logic [WORD_LEN-1:0] in_inst;
  logic                in_ready;
  logic                flush;
  logic                out_valid;
  logic [WORD_LEN-1:0] out_pc;
  logic [WORD_LEN-1:0] out_inst;
  logic                out_ready;
  logic [2:0]          count;

  int checks   = 0;
  int failures = 0;

  logic [63:0] expq [$];

  fetch_queue #(.WORD_LEN(WORD_LEN), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_ready (out_ready),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end else begin
      $display("ok   %s value=%0h @%0t", name, act, $time);
    end
  endtask

  // Move to just after the next rising edge, where inputs are changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampling mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (!rst || flush) begin
      expq.delete();
    end else begin
      if (in_valid && in_ready)
        expq.push_back({in_pc, in_inst});
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected actual=%0h_%0h expected=none @%0t", out_pc, out_inst, $time);
        end else begin
          logic [63:0] e;
          e = expq.pop_front();
          if ({out_pc, out_inst} !== e) begin
            failures++;
            $display("FAIL sb_pop actual=%0h_%0h expected=%0h_%0h @%0t",
                     out_pc, out_inst, e[63:32], e[31:0], $time);
          end else begin
            $display("pop  pc=%0h inst=%0h @%0t", out_pc, out_inst, $time);
          end
        end
      end
    end
  end

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_inst   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // Reset held for three cycles, outputs checked while in reset.
    tick(); tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_count",     64'(count),     64'd0);
    rst = 1'b1;
    #2;
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_out_pc",    64'(out_pc),    64'd0);
    chk("idle_out_inst",  64'(out_inst),  64'd0);
    chk("idle_in_ready",  64'(in_ready),  64'd1);
    chk("idle_count",     64'(count),     64'd0);

    // Single entry with decode ready.
    tick();
    in_valid  = 1'b1;
    in_pc     = 32'h4;
    in_inst   = 32'hE3A01005;
    out_ready = 1'b1;
    #2;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("single_bypass_valid", 64'(out_valid), 64'd1);
    chk("single_bypass_pc",    64'(out_pc),    64'h4);
    tick();
    in_valid = 1'b0;
    #2;
    chk("single_bypass_count", 64'(count), 64'd0);
    chk("single_bypass_after", 64'(out_valid), 64'd0);
`else
    chk("single_cycle_n_valid", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    #2;
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_pc",    64'(out_pc),    64'h4);
    chk("single_inst",  64'(out_inst),  64'hE3A01005);
    chk("single_count", 64'(count),     64'd1);
    tick();
    #2;
    chk("single_drained_count", 64'(count),     64'd0);
    chk("single_drained_valid", 64'(out_valid), 64'd0);
    chk("single_drained_pc",    64'(out_pc),    64'd0);
`endif

    // Fill with decode stalled; fifth entry must be held off.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h4 + 32'(4 * i);
      in_inst  = 32'hE0000000 + 32'(i);
      tick();
    end
    in_pc   = 32'h14;
    in_inst = 32'hE0000004;
    #2;
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_count",    64'(count),    64'd4);
    tick();
    #2;
    chk("full_hold_count", 64'(count),  64'd4);
    chk("full_hold_pc",    64'(out_pc), 64'h4);
    chk("full_hold_inst",  64'(out_inst), 64'hE0000000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    #2;
    chk("drain_in_ready", 64'(in_ready), 64'd1);
    chk("drain_count",    64'(count),    64'd3);
    chk("drain_head_pc",  64'(out_pc),   64'h8);
    tick(); tick(); tick();
    #2;
    chk("drain_empty_count", 64'(count),     64'd0);
    chk("drain_empty_valid", 64'(out_valid), 64'd0);

    // Streaming at count=2 across pointer wrap.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h100 + 32'(4 * i);
      in_inst  = 32'hE1000000 + 32'(i);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 2; i < 14; i++) begin
      in_pc   = 32'h100 + 32'(4 * i);
      in_inst = 32'hE1000000 + 32'(i);
      #2;
      chk($sformatf("stream_count_%0d", i), 64'(count), 64'd2);
      tick();
    end
    in_valid = 1'b0;
    #2;
    chk("stream_end_count", 64'(count), 64'd2);
    chk("stream_end_head",  64'(out_pc), 64'h130);
    tick(); tick();
    #2;
    chk("stream_drained", 64'(count), 64'd0);

    // Flush with three entries plus a same-cycle push and pop.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h200 + 32'(4 * i);
      in_inst  = 32'hE2000000 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    #2;
    chk("preflush_count", 64'(count), 64'd3);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_pc     = 32'h300;
    in_inst   = 32'hE3000000;
    out_ready = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #2;
    chk("flush_count",     64'(count),     64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready",  64'(in_ready),  64'd1);
    chk("flush_out_pc",    64'(out_pc),    64'd0);
    tick();
    #2;
    chk("flush_absent_count", 64'(count), 64'd0);

    // Asynchronous reset in mid-cycle with three entries.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_pc    = 32'h400 + 32'(4 * i);
      in_inst  = 32'hE4000000 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    #2;
    chk("prereset_count", 64'(count), 64'd3);
    rst = 1'b0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_count",     64'(count),     64'd0);
    chk("async_in_ready",  64'(in_ready),  64'd1);
    chk("async_out_pc",    64'(out_pc),    64'd0);
    tick();
    rst = 1'b1;

    // Empty queue with fetch and decode both ready.
    in_valid  = 1'b1;
    in_pc     = 32'h500;
    in_inst   = 32'hE5000000;
    out_ready = 1'b1;
    #2;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("bypass_valid", 64'(out_valid), 64'd1);
    chk("bypass_inst",  64'(out_inst),  64'hE5000000);
    tick();
    in_valid = 1'b0;
    #2;
    chk("bypass_count", 64'(count), 64'd0);
`else
    chk("nobypass_valid", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    #2;
    chk("nobypass_count", 64'(count),   64'd1);
    chk("nobypass_pc",    64'(out_pc),  64'h500);
    tick();
`endif

    tick(); tick();
    out_ready = 1'b0;
    chk("sb_leftover", 64'(expq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the instruction fetch stage and the decode stage of the pipelined ARM core. It buffers up to `DEPTH` fetched {PC, instruction} pairs so that fetch keeps running while decode stalls on hazards. On a taken branch the whole queue is discarded in one cycle. Fetch stalls on `~in_ready`, and decode consumes entries through a valid/ready handshake.

## Interface
- `WORD_LEN`, 32: width of the PC and instruction words.
- `DEPTH`, 4: number of entries; a power of two, at least 2.

- `clk`  in  1  pipeline clock; rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  fetch presents a {PC, instruction} pair.
- `in_pc`  in  `WORD_LEN`  PC+4 of the fetched instruction, as produced by fetch.
- `in_inst`  in  `WORD_LEN`  fetched instruction.
- `in_ready`  out  1  queue can accept an entry; fetch freeze = `~in_ready`.
- `flush`  in  1  branch taken; discard all entries.
- `out_valid`  out  1  the head entry is valid.
- `out_pc`  out  `WORD_LEN`  head PC.
- `out_inst`  out  `WORD_LEN`  head instruction.
- `out_ready`  in  1  decode accepts the head entry this cycle.
- `count`  out  `$clog2(DEPTH)+1`  current number of stored entries.

## Operation
- Storage is a circular buffer with `rd_ptr` and `wr_ptr`, each `$clog2(DEPTH)` bits, wrapping modulo `DEPTH`, plus the `count` register.
- push = `in_valid & in_ready & ~flush`; writes `mem[wr_ptr]` and increments `wr_ptr`.
- pop = `out_valid & out_ready & ~flush`; increments `rd_ptr`.
- Push and pop in the same cycle: `count` is unchanged and both pointers advance.
- `in_ready` = (`count` != `DEPTH`). It depends only on registered state. There is no combinational path from `out_ready` to `in_ready`, so a full queue refuses a push even when a pop occurs in the same cycle.
- `out_valid` = (`count` != 0). `out_pc` and `out_inst` are read from `mem[rd_ptr]` and forced to 0 when `out_valid` = 0, so decode sees a NOP.
- Flush has priority over everything else. The next state is `count` = 0 and `rd_ptr` = `wr_ptr` = 0. Any same-cycle push and pop are discarded. Memory contents are don't-care.
- Fetch may change `in_pc`/`in_inst` while `in_ready` = 0; nothing is sampled in that case.
- `out_pc`/`out_inst` hold stable while `out_valid` = 1 and `out_ready` = 0.
- Ordering is strict FIFO across pointer wrap-around.

## Timing
- Reset (`rst` = 0, asynchronous): `count` = 0, pointers = 0, `out_valid` = 0, `out_pc` = 0, `out_inst` = 0, `in_ready` = 1. This holds for the whole time `rst` is low. Reset in the middle of operation discards all entries immediately, without waiting for a clock edge.
- Release of reset is synchronised to `clk` by the top level. The first push can occur on the first rising edge after release.
- Latency: an entry pushed at edge N appears at the outputs after edge N, i.e. it is poppable in cycle N+1.
- Full: `in_ready` falls in the cycle after the push that reaches `DEPTH`. It rises in the cycle after the first pop.
- Empty: `out_valid` falls in the cycle after the last pop, unless a push occurs in the same cycle.
- Flush at edge N: `out_valid` = 0 and `in_ready` = 1 from cycle N+1.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined: when `count` = 0, `in_valid` = 1 and `flush` = 0:
  - `out_valid` = 1 and `out_pc`/`out_inst` = `in_pc`/`in_inst` combinationally.
  - If `out_ready` = 1, the entry is consumed without being stored: `count` stays 0 and the pointers do not move.
  - If `out_ready` = 0, the entry is stored normally.
  - Zero-cycle latency when empty.
- Not defined: no bypass path; latency is always one cycle as described in Timing.

## Test plan
- Reset then idle: `rst` = 0 for 3 cycles, then release -> `out_valid` = 0, `out_pc` = `out_inst` = 0, `in_ready` = 1, `count` = 0.
- Single entry, no bypass: push pc = 0x4, inst = 0xE3A01005 at edge N with `out_ready` = 1 -> `out_valid` = 1 with those values in cycle N+1; `count` returns to 0 after edge N+1.
- Fill/drain with `out_ready` = 0: push 5 entries at pc = 0x4..0x14 -> `in_ready` = 0 after the 4th push and the 5th is held off. Then pop all -> order 0x4, 0x8, 0xC, 0x10; `in_ready` = 1 after the first pop.
- Simultaneous push and pop at `count` = 2 -> `count` stays 2; 12 entries streamed through in order across pointer wrap with no loss.
- Flush with `count` = 3 plus same-cycle `in_valid` = 1 and `out_ready` = 1 -> next cycle `count` = 0, `out_valid` = 0, and the pushed entry is absent.
- Asynchronous reset asserted mid-cycle with `count` = 3 -> `out_valid` = 0 immediately, before the next edge. With `FETCH_QUEUE_BYPASS_EN`: empty queue, `in_valid` = 1, `out_ready` = 1 -> `out_valid` = 1 in the same cycle and `count` stays 0.
